banco_registros_mp: RTL and testbench

Parametrised successor of the 8088 register bank. It is a NUM_REGS x DATA_W register file with two independent combinational read ports and one byte-lane-masked write port. Writes enter through a 2-entry posted-write buffer with a valid/ready handshake and drain into the array one per cycle. Read ports forward pending buffered data when BYPASS=1. A per-register busy scoreboard supports reserving a destination register until its write-back commits.

---
 rtl/banco_pkg.sv | 15 +
 rtl/banco_registros_mp_if.sv | 35 +++
 rtl/banco_wbuf.sv | 64 ++++++
 rtl/banco_registros_mp.sv | 108 ++++++++++
 tb/tb_banco_registros_mp.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/banco_pkg.sv
// Shared defaults and types for the multi-port register bank and its posted-write buffer.
package banco_pkg;
    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
    localparam int BUF_DEPTH    = 2;

    // Default-width view of one posted write, for code that works at the default geometry.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]   addr;
        logic [DATA_W_DEF-1:0]   data;
        logic [DATA_W_DEF/8-1:0] be;
        logic                    valid;
    } wr_entry_t;
endpackage

// File: rtl/banco_registros_mp_if.sv
// Bus bundle of the register bank: write handshake, drain hold, two read ports, reservation port.
interface banco_registros_mp_if #(
    parameter int DATA_W   = banco_pkg::DATA_W_DEF,
    parameter int NUM_REGS = banco_pkg::NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_be;
    logic                hold;
    logic [ADDR_W-1:0]   rd_a_addr;
    logic [DATA_W-1:0]   rd_a_data;
    logic                rd_a_busy;
    logic [ADDR_W-1:0]   rd_b_addr;
    logic [DATA_W-1:0]   rd_b_data;
    logic                rd_b_busy;
    logic                rsv_valid;
    logic [ADDR_W-1:0]   rsv_addr;
    logic                rsv_ok;
    logic [1:0]          pending;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be, hold,
        output rd_a_addr, rd_b_addr, rsv_valid, rsv_addr,
        input  wr_ready, rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, rsv_ok, pending
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be, hold,
        input  rd_a_addr, rd_b_addr, rsv_valid, rsv_addr,
        output wr_ready, rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, rsv_ok, pending
    );
endinterface

// File: rtl/banco_wbuf.sv
// Two-entry posted-write FIFO; entry 0 is always the oldest, both entries exposed for forwarding.
module banco_wbuf
    import banco_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push_i,
    input  logic [ADDR_W-1:0]                 push_addr_i,
    input  logic [DATA_W-1:0]                 push_data_i,
    input  logic [BE_W-1:0]                   push_be_i,
    input  logic                              pop_i,
    output logic [BUF_DEPTH-1:0][ADDR_W-1:0]  ent_addr_o,
    output logic [BUF_DEPTH-1:0][DATA_W-1:0]  ent_data_o,
    output logic [BUF_DEPTH-1:0][BE_W-1:0]    ent_be_o,
    output logic [BUF_DEPTH-1:0]              ent_vld_o,
    output logic [1:0]                        count_o
);
    logic [1:0]                       count_q, count_d;
    logic [BUF_DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [BUF_DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [BUF_DEPTH-1:0][BE_W-1:0]   be_q, be_d;
    logic [1:0]                       wr_idx;

    // Pop shifts the newer entry down first, so a simultaneous push lands behind it.
    always_comb begin
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        wr_idx  = count_q - {1'b0, pop_i};
        if (pop_i) begin
            addr_d[0] = addr_q[1];
            data_d[0] = data_q[1];
            be_d[0]   = be_q[1];
        end
        if (push_i) begin
            addr_d[wr_idx[0]] = push_addr_i;
            data_d[wr_idx[0]] = push_data_i;
            be_d[wr_idx[0]]   = push_be_i;
        end
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= 2'd0;
        else       count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

    assign ent_addr_o = addr_q;
    assign ent_data_o = data_q;
    assign ent_be_o   = be_q;
    assign ent_vld_o  = {count_q == 2'd2, count_q != 2'd0};
    assign count_o    = count_q;
endmodule

// File: rtl/banco_registros_mp.sv
// Register file with two combinational read ports, buffered byte-masked writes and a busy scoreboard.
module banco_registros_mp
    import banco_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    banco_registros_mp_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_REGS-1:0][DATA_W-1:0]  mem_q, mem_d;
    logic [NUM_REGS-1:0]              busy_q, busy_d;
    logic [BUF_DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [BUF_DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [BUF_DEPTH-1:0][BE_W-1:0]   ent_be;
    logic [BUF_DEPTH-1:0]             ent_vld;
    logic [1:0]                       count;
    logic                             accept, drain, grant;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] base,
                                                      input logic [DATA_W-1:0] data,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = base;
        for (int i = 0; i < BE_W; i++)
            if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    // Oldest pending entry merges first so the newest one wins on overlapping lanes.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        if (in_range(a)) begin
            r = mem_q[a];
            if (BYPASS != 0) begin
                for (int e = 0; e < BUF_DEPTH; e++)
                    if (ent_vld[e] && ent_addr[e] == a) r = merge_lanes(r, ent_data[e], ent_be[e]);
            end
        end
        return r;
    endfunction

    function automatic logic busy_of(input logic [ADDR_W-1:0] a);
        return in_range(a) ? busy_q[a] : 1'b0;
    endfunction

    assign bus.wr_ready = !reset && (count != 2'd2);
    assign accept       = bus.wr_valid && bus.wr_ready;
    assign drain        = (count != 2'd0) && !bus.hold;
    assign grant        = !reset && bus.rsv_valid && in_range(bus.rsv_addr) && !busy_q[bus.rsv_addr];

    banco_wbuf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_wbuf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .push_addr_i (bus.wr_addr),
        .push_data_i (bus.wr_data),
        .push_be_i   (bus.wr_be),
        .pop_i       (drain),
        .ent_addr_o  (ent_addr),
        .ent_data_o  (ent_data),
        .ent_be_o    (ent_be),
        .ent_vld_o   (ent_vld),
        .count_o     (count)
    );

    // Clear-on-commit is applied before set-on-grant, so a grant to the same register wins.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (drain && in_range(ent_addr[0])) begin
            mem_d[ent_addr[0]] = merge_lanes(mem_q[ent_addr[0]], ent_data[0], ent_be[0]);
            if (|ent_be[0]) busy_d[ent_addr[0]] = 1'b0;
        end
        if (grant) busy_d[bus.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign bus.rd_a_data = read_port(bus.rd_a_addr);
    assign bus.rd_b_data = read_port(bus.rd_b_addr);
    assign bus.rd_a_busy = busy_of(bus.rd_a_addr);
    assign bus.rd_b_busy = busy_of(bus.rd_b_addr);
    assign bus.rsv_ok    = grant;
    assign bus.pending   = count;
endmodule

// File: tb/tb_banco_registros_mp.sv
// Directed bench: a forwarding instance and an array-only instance share every input.
module tb_banco_registros_mp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        hold = 1'b0;
    logic [2:0]  rd_a_addr = '0;
    logic [2:0]  rd_b_addr = '0;
    logic        rsv_valid = 1'b0;
    logic [2:0]  rsv_addr = '0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    banco_registros_mp_if b1 ();
    banco_registros_mp_if b0 ();

    assign b1.wr_valid = wr_valid;   assign b0.wr_valid = wr_valid;
    assign b1.wr_addr  = wr_addr;    assign b0.wr_addr  = wr_addr;
    assign b1.wr_data  = wr_data;    assign b0.wr_data  = wr_data;
    assign b1.wr_be    = wr_be;      assign b0.wr_be    = wr_be;
    assign b1.hold     = hold;       assign b0.hold     = hold;
    assign b1.rd_a_addr = rd_a_addr; assign b0.rd_a_addr = rd_a_addr;
    assign b1.rd_b_addr = rd_b_addr; assign b0.rd_b_addr = rd_b_addr;
    assign b1.rsv_valid = rsv_valid; assign b0.rsv_valid = rsv_valid;
    assign b1.rsv_addr  = rsv_addr;  assign b0.rsv_addr  = rsv_addr;

    banco_registros_mp #(.BYPASS(1)) dut_byp (.clk(clk), .reset(reset), .bus(b1));
    banco_registros_mp #(.BYPASS(0)) dut_arr (.clk(clk), .reset(reset), .bus(b0));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic test_reset();
        put(3'd1, 16'hFFFF, 2'b11);
        rsv_valid = 1'b1; rsv_addr = 3'd1;
        repeat (3) begin
            step();
            n_total++; if (b1.wr_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", b1.wr_ready); else n_pass++;
            n_total++; if (b1.pending !== 2'd0) $display("FAIL rst_pending got=%0d exp=0", b1.pending); else n_pass++;
        end
        n_total++; if (b1.rsv_ok !== 1'b0) $display("FAIL rst_rsv_ok got=%b exp=0", b1.rsv_ok); else n_pass++;
        wr_valid = 1'b0; rsv_valid = 1'b0;
        reset = 1'b0;
        step();
        n_total++; if (b1.wr_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", b1.wr_ready); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            rd_a_addr = 3'(i);
            #1;
            n_total++; if (b1.rd_a_data !== 16'h0000) $display("FAIL rst_reg%0d got=%h exp=0000", i, b1.rd_a_data); else n_pass++;
            n_total++; if (b1.rd_a_busy !== 1'b0) $display("FAIL rst_busy%0d got=%b exp=0", i, b1.rd_a_busy); else n_pass++;
        end
    endtask

    task automatic test_byte_lanes();
        rd_a_addr = 3'd2;
        put(3'd2, 16'h1234, 2'b11);
        step();
        n_total++; if (b1.rd_a_data !== 16'h1234) $display("FAIL bl_fwd1 got=%h exp=1234", b1.rd_a_data); else n_pass++;
        n_total++; if (b0.rd_a_data !== 16'h0000) $display("FAIL bl_arr1 got=%h exp=0000", b0.rd_a_data); else n_pass++;
        put(3'd2, 16'hAB00, 2'b10);
        step();
        n_total++; if (b0.rd_a_data !== 16'h1234) $display("FAIL bl_arr2 got=%h exp=1234", b0.rd_a_data); else n_pass++;
        n_total++; if (b1.rd_a_data !== 16'hAB34) $display("FAIL bl_fwd2 got=%h exp=AB34", b1.rd_a_data); else n_pass++;
        n_total++; if (b1.pending !== 2'd1) $display("FAIL bl_pending got=%0d exp=1", b1.pending); else n_pass++;
        wr_valid = 1'b0;
        step();
        step();
        n_total++; if (b0.rd_a_data !== 16'hAB34) $display("FAIL bl_final got=%h exp=AB34", b0.rd_a_data); else n_pass++;
        n_total++; if (b1.pending !== 2'd0) $display("FAIL bl_empty got=%0d exp=0", b1.pending); else n_pass++;
    endtask

    task automatic test_bypass();
        hold = 1'b1;
        rd_b_addr = 3'd5;
        put(3'd5, 16'hBEEF, 2'b11);
        #1;
        n_total++; if (b1.rd_b_data !== 16'h0000) $display("FAIL byp_no_passthru got=%h exp=0000", b1.rd_b_data); else n_pass++;
        step();
        wr_valid = 1'b0;
        #1;
        n_total++; if (b1.rd_b_data !== 16'hBEEF) $display("FAIL byp_fwd got=%h exp=BEEF", b1.rd_b_data); else n_pass++;
        n_total++; if (b0.rd_b_data !== 16'h0000) $display("FAIL byp_arr got=%h exp=0000", b0.rd_b_data); else n_pass++;
        step();
        n_total++; if (b1.pending !== 2'd1) $display("FAIL byp_frozen got=%0d exp=1", b1.pending); else n_pass++;
        hold = 1'b0;
        step();
        n_total++; if (b0.rd_b_data !== 16'hBEEF) $display("FAIL byp_commit got=%h exp=BEEF", b0.rd_b_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        hold = 1'b1;
        rd_a_addr = 3'd0;
        rd_b_addr = 3'd1;
        put(3'd0, 16'h1111, 2'b11);
        step();
        put(3'd0, 16'h2222, 2'b01);
        step();
        put(3'd1, 16'h3333, 2'b11);
        n_total++; if (b1.pending !== 2'd2) $display("FAIL bp_full got=%0d exp=2", b1.pending); else n_pass++;
        n_total++; if (b1.wr_ready !== 1'b0) $display("FAIL bp_ready got=%b exp=0", b1.wr_ready); else n_pass++;
        step();
        n_total++; if (b1.pending !== 2'd2) $display("FAIL bp_reject got=%0d exp=2", b1.pending); else n_pass++;
        n_total++; if (b1.rd_a_data !== 16'h1122) $display("FAIL bp_fwd2 got=%h exp=1122", b1.rd_a_data); else n_pass++;
        hold = 1'b0;
        step();
        n_total++; if (b1.pending !== 2'd1) $display("FAIL bp_drain1 got=%0d exp=1", b1.pending); else n_pass++;
        n_total++; if (b0.rd_a_data !== 16'h1111) $display("FAIL bp_order1 got=%h exp=1111", b0.rd_a_data); else n_pass++;
        n_total++; if (b1.wr_ready !== 1'b1) $display("FAIL bp_ready_again got=%b exp=1", b1.wr_ready); else n_pass++;
        step();
        wr_valid = 1'b0;
        n_total++; if (b1.pending !== 2'd1) $display("FAIL bp_accept3 got=%0d exp=1", b1.pending); else n_pass++;
        n_total++; if (b0.rd_a_data !== 16'h1122) $display("FAIL bp_order2 got=%h exp=1122", b0.rd_a_data); else n_pass++;
        step();
        n_total++; if (b0.rd_b_data !== 16'h3333) $display("FAIL bp_third got=%h exp=3333", b0.rd_b_data); else n_pass++;
        n_total++; if (b1.pending !== 2'd0) $display("FAIL bp_empty got=%0d exp=0", b1.pending); else n_pass++;
    endtask

    task automatic test_scoreboard();
        rd_a_addr = 3'd3;
        rsv_valid = 1'b1; rsv_addr = 3'd3;
        #1;
        n_total++; if (b1.rsv_ok !== 1'b1) $display("FAIL sb_grant got=%b exp=1", b1.rsv_ok); else n_pass++;
        n_total++; if (b1.rd_a_busy !== 1'b0) $display("FAIL sb_busy_pre got=%b exp=0", b1.rd_a_busy); else n_pass++;
        step();
        n_total++; if (b1.rd_a_busy !== 1'b1) $display("FAIL sb_busy_set got=%b exp=1", b1.rd_a_busy); else n_pass++;
        n_total++; if (b1.rsv_ok !== 1'b0) $display("FAIL sb_deny got=%b exp=0", b1.rsv_ok); else n_pass++;
        rsv_valid = 1'b0;
        put(3'd3, 16'h00FF, 2'b01);
        step();
        wr_valid = 1'b0;
        n_total++; if (b1.rd_a_busy !== 1'b1) $display("FAIL sb_busy_buffered got=%b exp=1", b1.rd_a_busy); else n_pass++;
        step();
        n_total++; if (b1.rd_a_busy !== 1'b0) $display("FAIL sb_busy_clear got=%b exp=0", b1.rd_a_busy); else n_pass++;
        n_total++; if (b0.rd_a_data !== 16'h00FF) $display("FAIL sb_data got=%h exp=00FF", b0.rd_a_data); else n_pass++;
        // Empty byte mask must neither write nor release the reservation.
        rd_a_addr = 3'd4;
        rsv_valid = 1'b1; rsv_addr = 3'd4;
        step();
        rsv_valid = 1'b0;
        put(3'd4, 16'hDEAD, 2'b00);
        step();
        wr_valid = 1'b0;
        step();
        n_total++; if (b1.rd_a_busy !== 1'b1) $display("FAIL sb_be0_busy got=%b exp=1", b1.rd_a_busy); else n_pass++;
        n_total++; if (b0.rd_a_data !== 16'h0000) $display("FAIL sb_be0_data got=%h exp=0000", b0.rd_a_data); else n_pass++;
        // Drain and reservation to the same busy register: deny, busy ends clear.
        hold = 1'b1;
        put(3'd4, 16'h4444, 2'b11);
        step();
        wr_valid = 1'b0;
        hold = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 3'd4;
        #1;
        n_total++; if (b1.rsv_ok !== 1'b0) $display("FAIL sb_same_busy_grant got=%b exp=0", b1.rsv_ok); else n_pass++;
        step();
        rsv_valid = 1'b0;
        n_total++; if (b1.rd_a_busy !== 1'b0) $display("FAIL sb_same_busy_end got=%b exp=0", b1.rd_a_busy); else n_pass++;
        // Drain and reservation to the same idle register: grant wins.
        rd_b_addr = 3'd6;
        hold = 1'b1;
        put(3'd6, 16'h6666, 2'b11);
        step();
        wr_valid = 1'b0;
        hold = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 3'd6;
        #1;
        n_total++; if (b1.rsv_ok !== 1'b1) $display("FAIL sb_same_idle_grant got=%b exp=1", b1.rsv_ok); else n_pass++;
        step();
        rsv_valid = 1'b0;
        n_total++; if (b1.rd_b_busy !== 1'b1) $display("FAIL sb_same_idle_end got=%b exp=1", b1.rd_b_busy); else n_pass++;
        n_total++; if (b0.rd_b_data !== 16'h6666) $display("FAIL sb_same_idle_data got=%h exp=6666", b0.rd_b_data); else n_pass++;
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        rd_a_addr = 3'd7;
        put(3'd7, 16'h7777, 2'b11);
        step();
        put(3'd7, 16'h7070, 2'b11);
        step();
        wr_valid = 1'b0;
        n_total++; if (b1.pending !== 2'd2) $display("FAIL rm_full got=%0d exp=2", b1.pending); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (b1.pending !== 2'd0) $display("FAIL rm_async_pending got=%0d exp=0", b1.pending); else n_pass++;
        n_total++; if (b1.wr_ready !== 1'b0) $display("FAIL rm_async_ready got=%b exp=0", b1.wr_ready); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        hold = 1'b0;
        step();
        step();
        n_total++; if (b1.rd_a_data !== 16'h0000) $display("FAIL rm_no_commit got=%h exp=0000", b1.rd_a_data); else n_pass++;
        n_total++; if (b1.rd_b_busy !== 1'b0) $display("FAIL rm_busy got=%b exp=0", b1.rd_b_busy); else n_pass++;
        n_total++; if (b1.pending !== 2'd0) $display("FAIL rm_pending got=%0d exp=0", b1.pending); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_bypass();
        test_back_to_back();
        test_scoreboard();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
